gpio_ctrl: RTL and testbench

//  Parametrised GPIO port: WIDTH tri-state pins with per-bit direction, atomic SET/CLR/TGL output writes,

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_sync.sv | 26 ++
 rtl/gpio_ctrl.sv | 115 +++++++++++
 tb/tb_gpio_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: bus geometry, register map and limits.
package gpio_pkg;

    localparam int GPIO_DATA_W    = 32;
    localparam int GPIO_ADDR_W    = 4;
    localparam int GPIO_MAX_WIDTH = 32;
    localparam int GPIO_MAX_SYNC  = 4;
    localparam int GPIO_NUM_REGS  = 9;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_DIN     = 4'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_DOUT    = 4'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR     = 4'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_SET     = 4'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_CLR     = 4'd4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_TGL     = 4'd5;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_RISE_EN = 4'd6;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_FALL_EN = 4'd7;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_STAT    = 4'd8;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser bringing asynchronous pin levels into the i_Clk domain.
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             i_Clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: this array is a flop chain, not a RAM, so every element is reset.
            for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
        end else begin
            r_chain[0] <= i_D;
            for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    assign o_Q = r_chain[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO port: tri-state pins, atomic SET/CLR/TGL writes, synchronised inputs,
// per-bit edge detection with sticky W1C status and a level interrupt.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_rst_n,
    inout  wire  [WIDTH-1:0]       IO,
    input  logic [GPIO_ADDR_W-1:0] i_Addr,
    input  logic                   i_WE,
    input  logic                   i_RE,
    input  logic [GPIO_DATA_W-1:0] i_WD,
    output logic [GPIO_DATA_W-1:0] o_RD,
    output logic                   o_Irq
);

    // Detection stays off until the synchroniser and DIN_Q hold real pin levels.
    localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]       r_dout, r_dir, r_rise_en, r_fall_en, r_stat, r_din_q;
    logic [WIDTH-1:0]       w_din, w_wd, w_edge, w_w1c;
    logic [2:0]             r_arm_cnt;
    logic                   w_armed;
    logic                   r_irq;
    logic [GPIO_DATA_W-1:0] r_rd, w_rd;

    assign w_wd = i_WD[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign IO[i] = r_dir[i] ? r_dout[i] : 1'bz;
    end

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_Clk   (i_Clk),
        .i_rst_n (i_rst_n),
        .i_D     (IO),
        .o_Q     (w_din)
    );

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arm_cnt <= '0;
            r_din_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
            r_din_q <= w_din;
        end
    end

    assign w_armed = (r_arm_cnt == ARM_COUNT);
    assign w_edge  = w_armed ? ((w_din & ~r_din_q & r_rise_en) | (~w_din & r_din_q & r_fall_en))
                             : '0;
    assign w_w1c   = (i_WE && i_Addr == GPIO_STAT) ? w_wd : '0;

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout    <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (i_WE) begin
            case (i_Addr)
                GPIO_DOUT:    r_dout    <= w_wd;
                GPIO_DIR:     r_dir     <= w_wd;
                GPIO_SET:     r_dout    <= r_dout | w_wd;
                GPIO_CLR:     r_dout    <= r_dout & ~w_wd;
                GPIO_TGL:     r_dout    <= r_dout ^ w_wd;
                GPIO_RISE_EN: r_rise_en <= w_wd;
                GPIO_FALL_EN: r_fall_en <= w_wd;
                default:      ;
            endcase
        end
    end

    // A new edge overrides a clear landing on the same bit in the same cycle.
    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= (r_stat & ~w_w1c) | w_edge;
            r_irq  <= |r_stat;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no address path can infer a latch.
        w_rd = '0;
        case (i_Addr)
            GPIO_DIN:     w_rd = GPIO_DATA_W'(w_din);
            GPIO_DOUT:    w_rd = GPIO_DATA_W'(r_dout);
            GPIO_DIR:     w_rd = GPIO_DATA_W'(r_dir);
            GPIO_RISE_EN: w_rd = GPIO_DATA_W'(r_rise_en);
            GPIO_FALL_EN: w_rd = GPIO_DATA_W'(r_fall_en);
            GPIO_STAT:    w_rd = GPIO_DATA_W'(r_stat);
            default:      w_rd = '0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rd <= '0;
        else if (i_RE) r_rd <= w_rd;
    end

    assign o_RD  = r_rd;
    assign o_Irq = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: 32-pin instance with read scoreboard plus an 8-pin instance.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic clk = 1'b0;
    logic rst_n, rst8_n;
    always #5 clk = ~clk;

    wire  [31:0] io;
    logic [31:0] tb_oe, tb_val;
    for (genvar i = 0; i < 32; i++) begin : g_tb_pin
        assign io[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    logic [3:0]  addr;
    logic        we, re;
    logic [31:0] wd, rd;
    logic        irq;

    gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .i_Clk(clk), .i_rst_n(rst_n), .IO(io), .i_Addr(addr), .i_WE(we), .i_RE(re),
        .i_WD(wd), .o_RD(rd), .o_Irq(irq)
    );

    wire  [7:0]  io8;
    logic [3:0]  addr8;
    logic        we8, re8;
    logic [31:0] wd8, rd8;
    logic        irq8;

    gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .i_Clk(clk), .i_rst_n(rst8_n), .IO(io8), .i_Addr(addr8), .i_WE(we8), .i_RE(re8),
        .i_WD(wd8), .o_RD(rd8), .o_Irq(irq8)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        bit          we;
        bit          re;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Read data is valid one cycle after the strobe; pop the expectation pushed at issue.
    bit rd_pend = 1'b0;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: got read data 0x%08h with no expectation queued", rd);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.name, rd, mon_e.exp);
            end
        end
        rd_pend = re;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic bus(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string name);
        we = w; re = r; addr = a; wd = d;
        if (r) sb.push_back('{name: name, exp: exp});
        cyc();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d, 32'h0, "");
    endtask

    task automatic rdx(input logic [3:0] a, input logic [31:0] exp, input string name);
        bus(1'b0, 1'b1, a, 32'h0, exp, name);
    endtask

    task automatic v(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string name);
        vecs.push_back('{we: w, re: r, addr: a, wd: d, exp: exp, name: name});
    endtask

    task automatic run_vecs();
        foreach (vecs[k]) begin
            if (vecs[k].we || vecs[k].re)
                bus(vecs[k].we, vecs[k].re, vecs[k].addr, vecs[k].wd, vecs[k].exp, vecs[k].name);
            else
                idle(1);
        end
        vecs.delete();
    endtask

    task automatic wr8(input logic [3:0] a, input logic [31:0] d);
        we8 = 1'b1; addr8 = a; wd8 = d;
        cyc();
        we8 = 1'b0;
    endtask

    task automatic rd8c(input logic [3:0] a, input logic [31:0] exp, input string name);
        re8 = 1'b1; addr8 = a;
        cyc();
        re8 = 1'b0;
        @(negedge clk);
        check(name, rd8, exp);
        cyc();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        we = 0; re = 0; addr = 0; wd = 0;
        we8 = 0; re8 = 0; addr8 = 0; wd8 = 0;
        tb_oe = '1; tb_val = '0;
        rst_n = 1'b0; rst8_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst8_n = 1'b1;

        // Reset state: every address reads zero, no interrupt.
        check("rst_rd", rd, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 16; a++) v(1'b0, 1'b1, 4'(a), 32'h0, 32'h0, $sformatf("rst_addr_%0d", a));
        run_vecs();

        // Pins are inputs after reset: externally driven levels reach DIN unopposed.
        tb_val = 32'hDEAD_BEEF;
        idle(3);
        rdx(GPIO_DIN, 32'hDEAD_BEEF, "din_all_inputs");

        // Output path, atomic ops, reserved and write-only addresses.
        tb_oe  = 32'hFFFF_FF00;
        tb_val = 32'h5A5A_5A00;
        v(1, 0, GPIO_DIR,     32'h0000_00FF, 0, "");
        v(1, 0, GPIO_DOUT,    32'h0000_00A5, 0, "");
        v(1, 0, GPIO_SET,     32'h0000_0002, 0, "");
        v(1, 0, GPIO_CLR,     32'h0000_0080, 0, "");
        v(1, 0, GPIO_TGL,     32'h0000_000F, 0, "");
        v(0, 1, GPIO_DOUT,    0, 32'h0000_0028, "dout_atomic");
        v(0, 1, GPIO_DIR,     0, 32'h0000_00FF, "dir_rb");
        v(0, 1, GPIO_SET,     0, 32'h0, "set_wo");
        v(0, 1, GPIO_CLR,     0, 32'h0, "clr_wo");
        v(0, 1, GPIO_TGL,     0, 32'h0, "tgl_wo");
        v(1, 0, 4'd9,         32'hFFFF_FFFF, 0, "");
        v(0, 1, 4'd9,         0, 32'h0, "rsvd9");
        v(0, 1, 4'd15,        0, 32'h0, "rsvd15");
        v(1, 1, GPIO_DOUT,    32'h0000_0013, 32'h0000_0028, "rw_same_cycle_pre");
        v(0, 1, GPIO_DOUT,    0, 32'h0000_0013, "rw_same_cycle_post");
        v(1, 0, GPIO_DOUT,    32'h0000_0028, 0, "");
        v(0, 0, 4'd0, 0, 0, "");
        v(0, 0, 4'd0, 0, 0, "");
        v(0, 0, 4'd0, 0, 0, "");
        v(0, 0, 4'd0, 0, 0, "");
        v(0, 1, GPIO_DIN,     0, 32'h5A5A_5A28, "din_mixed_dir");
        v(1, 0, GPIO_RISE_EN, 32'hA5A5_A5A5, 0, "");
        v(1, 0, GPIO_FALL_EN, 32'h3C3C_3C3C, 0, "");
        v(0, 1, GPIO_RISE_EN, 0, 32'hA5A5_A5A5, "rise_en_rb");
        v(0, 1, GPIO_FALL_EN, 0, 32'h3C3C_3C3C, "fall_en_rb");
        v(1, 0, GPIO_RISE_EN, 32'h0, 0, "");
        v(1, 0, GPIO_FALL_EN, 32'h0, 0, "");
        v(0, 1, GPIO_STAT,    0, 32'h0, "stat_quiet");
        run_vecs();
        check("io_low_byte", {24'h0, io[7:0]}, 32'h28);
        wr(GPIO_TGL, 32'h1);
        check("io_next_cycle_a", {24'h0, io[7:0]}, 32'h29);
        wr(GPIO_TGL, 32'h1);
        check("io_next_cycle_b", {24'h0, io[7:0]}, 32'h28);

        // Rise on bit 3: synchroniser latency, STAT set, interrupt one cycle later.
        wr(GPIO_DIR, 32'h0000_00F7);
        tb_oe[3] = 1'b1; tb_val[3] = 1'b0;
        wr(GPIO_RISE_EN, 32'h0000_0008);
        idle(4);
        rdx(GPIO_STAT, 32'h0, "stat_pre_rise");
        rdx(GPIO_DIN, 32'h5A5A_5A20, "din_pre_rise");
        tb_val[3] = 1'b1;
        rdx(GPIO_DIN, 32'h5A5A_5A20, "din_sync_lat1");
        rdx(GPIO_DIN, 32'h5A5A_5A20, "din_sync_lat2");
        rdx(GPIO_DIN, 32'h5A5A_5A28, "din_sync_done");
        check("irq_before_stat", {31'b0, irq}, 32'h0);
        rdx(GPIO_STAT, 32'h0000_0008, "stat_rise3");
        check("irq_after_stat", {31'b0, irq}, 32'h1);

        // Edge on bit 5 lands in the same cycle as its W1C: the set wins.
        wr(GPIO_STAT, 32'h0000_0008);
        wr(GPIO_DIR, 32'h0000_00D7);
        tb_oe[5] = 1'b1; tb_val[5] = 1'b0;
        wr(GPIO_RISE_EN, 32'h0000_0028);
        idle(4);
        rdx(GPIO_STAT, 32'h0, "stat_cleared");
        check("irq_cleared", {31'b0, irq}, 32'h0);
        tb_val[5] = 1'b1;
        idle(2);
        wr(GPIO_STAT, 32'h0000_0020);
        rdx(GPIO_STAT, 32'h0000_0020, "stat_set_wins");
        wr(GPIO_RISE_EN, 32'h0);
        rdx(GPIO_STAT, 32'h0000_0020, "stat_en_off_keeps");
        wr(GPIO_STAT, 32'h0000_0020);
        check("irq_lags_w1c", {31'b0, irq}, 32'h1);
        idle(1);
        check("irq_drops", {31'b0, irq}, 32'h0);
        rdx(GPIO_STAT, 32'h0, "stat_w1c");

        // Reset mid-operation with a pin held high through release: arming blocks a false rise.
        rdx(GPIO_DOUT, 32'h0000_0028, "dout_pre_reset");
        idle(1);
        rst_n = 1'b0;
        #1;
        check("rd_async_reset", rd, 32'h0);
        tb_oe = '1; tb_val = 32'h5A5A_5A08;
        idle(2);
        rst_n = 1'b1;
        wr(GPIO_RISE_EN, 32'hFFFF_FFFF);
        rdx(GPIO_DOUT, 32'h0, "dout_after_reset");
        rdx(GPIO_DIR, 32'h0, "dir_after_reset");
        idle(4);
        rdx(GPIO_STAT, 32'h0, "stat_armed_no_spurious");
        check("irq_armed_no_spurious", {31'b0, irq}, 32'h0);
        rdx(GPIO_DIN, 32'h5A5A_5A08, "din_after_reset");
        tb_val[3] = 1'b0;
        idle(4);
        rdx(GPIO_STAT, 32'h0, "stat_fall_disabled");
        wr(GPIO_FALL_EN, 32'h0000_0200);
        tb_val[9] = 1'b0;
        idle(4);
        rdx(GPIO_STAT, 32'h0000_0200, "stat_fall9");
        check("irq_fall9", {31'b0, irq}, 32'h1);

        // 8-pin build: upper bits masked, toggle-driven fall, reset during a write.
        wr8(GPIO_DOUT, 32'hFFFF_FFFF);
        rd8c(GPIO_DOUT, 32'h0000_00FF, "w8_dout_mask");
        wr8(GPIO_DIR, 32'hFFFF_FFFF);
        rd8c(GPIO_DIR, 32'h0000_00FF, "w8_dir_mask");
        idle(4);
        wr8(GPIO_FALL_EN, 32'h0000_00FF);
        wr8(GPIO_TGL, 32'h0000_0001);
        idle(4);
        rd8c(GPIO_STAT, 32'h0000_0001, "w8_stat_fall");
        check("w8_irq", {31'b0, irq8}, 32'h1);
        rd8c(GPIO_DIN, 32'h0000_00FE, "w8_din_readback");
        we8 = 1'b1; addr8 = GPIO_DIR; wd8 = 32'h0;
        #2;
        rst8_n = 1'b0;
        #1;
        check("w8_rd_async_reset", rd8, 32'h0);
        check("w8_irq_async_reset", {31'b0, irq8}, 32'h0);
        cyc();
        we8 = 1'b0;
        cyc();
        rst8_n = 1'b1;
        rd8c(GPIO_DOUT, 32'h0, "w8_dout_reset");
        rd8c(GPIO_DIR, 32'h0, "w8_dir_reset");
        rd8c(GPIO_FALL_EN, 32'h0, "w8_fall_en_reset");
        rd8c(GPIO_STAT, 32'h0, "w8_stat_reset");
        check("w8_irq_reset", {31'b0, irq8}, 32'h0);

        idle(3);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
